// File: rtl/arith_unit_seq.sv
// arith_unit_seq
// Slice-serial adder: D = X + Ysel + cin, where Ysel is chosen per bit from
// Y, ~Y, all-zeros or all-ones. The WIDTH-bit operation runs SLICE bits per
// clock through a SLICE-bit ripple adder, so it takes N = WIDTH/SLICE BUSY
// cycles. Valid/ready handshakes are used on both sides. The unit also
// reports carry, signed overflow, zero and negative flags.
//
// Ports:
//   clk, rst         clock (rising edge) and async active-high reset
//   in_valid         operand request valid
//   in_ready         unit can accept an operation (IDLE)
//   x, y             WIDTH-bit operands
//   cin, sel         carry-in; Y-select (00=Y, 01=~Y, 10=zeros, 11=ones)
//   out_valid        result valid (DONE)
//   out_ready        consumer accepts the result
//   d                WIDTH-bit result
//   cout, ovf        carry out of the MSB; signed overflow
//   zero, neg        d == 0; d[WIDTH-1]
//
// state | meaning
// IDLE  | waiting for in_valid; operands captured at the accept edge
// BUSY  | one slice per edge, LSB slice first; running carry between slices
// DONE  | result and flags held until out_ready
module arith_unit_seq #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic [1:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] x_r;
  logic [WIDTH-1:0] y_r;
  logic [1:0]       sel_r;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] ysel;
  logic [SLICE-1:0] xs;
  logic [SLICE-1:0] ys;
  logic [SLICE:0]   ssum;
  logic [WIDTH-1:0] d_next;
  logic             last;
  logic             c_msb;

  // Ysel comes from the captured y and sel, so the operand inputs are free to
  // change once the operation has been accepted.
  always_comb begin
    ysel = y_r;
    case (sel_r)
      2'b00: ysel = y_r;
      2'b01: ysel = ~y_r;
      2'b10: ysel = '0;
      2'b11: ysel = '1;
      default: ysel = y_r;
    endcase
  end

  // Slice select. A mux over constant part-selects keeps every index static.
  always_comb begin
    xs = '0;
    ys = '0;
    for (int i = 0; i < N; i++) begin
      if (cnt == CW'(i)) begin
        xs = x_r[i*SLICE +: SLICE];
        ys = ysel[i*SLICE +: SLICE];
      end
    end
  end

  // The only carry path is SLICE bits deep, plus one registered carry.
  assign ssum = {1'b0, xs} + {1'b0, ys} + {{SLICE{1'b0}}, carry};

  always_comb begin
    d_next = d;
    for (int i = 0; i < N; i++) begin
      if (cnt == CW'(i)) d_next[i*SLICE +: SLICE] = ssum[SLICE-1:0];
    end
  end

  assign last = (cnt == CW'(N - 1));

  // The carry into the slice MSB is recovered from sum ^ a ^ b at that bit.
  // This also holds when SLICE == 1.
  assign c_msb = ssum[SLICE-1] ^ xs[SLICE-1] ^ ys[SLICE-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = BUSY;
      end
      BUSY: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_r   <= '0;
      y_r   <= '0;
      sel_r <= 2'b00;
      carry <= 1'b0;
      cnt   <= '0;
      d     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
      neg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_r   <= x;
            y_r   <= y;
            sel_r <= sel;
            carry <= cin;
            cnt   <= '0;
          end
        end
        BUSY: begin
          d     <= d_next;
          carry <= ssum[SLICE];
          if (last) begin
            cnt  <= '0;
            cout <= ssum[SLICE];
            ovf  <= c_msb ^ ssum[SLICE];
            zero <= (d_next == '0);
            neg  <= d_next[WIDTH-1];
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arith_unit_seq.sv
module tb_arith_unit_seq;

  typedef struct packed {
    logic [15:0] d;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        neg;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;

  logic        in_valid, in_ready, cin, out_valid, out_ready, cout, ovf, zero, neg;
  logic [15:0] x, y, d;
  logic [1:0]  sel;

  logic        in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1, ovf1, zero1, neg1;
  logic [15:0] x1, y1, d1;
  logic [1:0]  sel1;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  bit force_bp = 0;

  res_t q[$];
  int   stamp_q[$];
  res_t q1[$];
  int   stamp1_q[$];

  arith_unit_seq #(.WIDTH(16), .SLICE(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .cin(cin), .sel(sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
  );

  arith_unit_seq #(.WIDTH(16), .SLICE(16)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .x(x1), .y(y1), .cin(cin1), .sel(sel1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .d(d1), .cout(cout1), .ovf(ovf1), .zero(zero1), .neg(neg1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: whole-word arithmetic on integers.
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic c, input logic [1:0] s);
    res_t r;
    int unsigned yv, sum;
    int sa, sb, ss;
    case (s)
      2'd0: yv = b;
      2'd1: yv = 65535 - b;
      2'd2: yv = 0;
      default: yv = 65535;
    endcase
    sum    = a + yv + c;
    r.d    = sum[15:0];
    r.cout = (sum > 65535);
    sa     = (a  >= 32768) ? int'(a) - 65536 : int'(a);
    sb     = (yv >= 32768) ? int'(yv) - 65536 : int'(yv);
    ss     = sa + sb + int'(c);
    r.ovf  = (ss > 32767) || (ss < -32768);
    r.zero = (r.d == 16'h0000);
    r.neg  = r.d[15];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h7FFF;
      3: return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  // While waiting for in_ready the request stays up and the operands churn;
  // the values present at the accept edge are the ones modelled.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c,
                      input logic [1:0] s, input bit push);
    int g = 0;
    @(negedge clk);
    in_valid = 1'b1;
    while (!in_ready && g < 300) begin
      x = 16'($urandom); y = 16'($urandom); cin = 1'($urandom); sel = 2'($urandom);
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      checks++; fails++;
      $display("FAIL accept_timeout: in_ready stayed %b, required 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    x = a; y = b; cin = c; sel = s;
    if (push) begin
      q.push_back(model(a, b, c, s));
      stamp_q.push_back(cyc + 1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x = 16'($urandom); y = 16'($urandom); cin = 1'($urandom); sel = 2'($urandom);
  endtask

  task automatic send1(input logic [15:0] a, input logic [15:0] b, input logic c,
                       input logic [1:0] s);
    int g = 0;
    @(negedge clk);
    in_valid1 = 1'b1;
    while (!in_ready1 && g < 300) begin
      x1 = 16'($urandom); y1 = 16'($urandom);
      @(negedge clk);
      g++;
    end
    if (!in_ready1) begin
      checks++; fails++;
      $display("FAIL accept1_timeout: in_ready1 stayed %b, required 1", in_ready1);
      in_valid1 = 1'b0;
      return;
    end
    x1 = a; y1 = b; cin1 = c; sel1 = s;
    q1.push_back(model(a, b, c, s));
    stamp1_q.push_back(cyc + 1);
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    x1 = 16'($urandom); y1 = 16'($urandom);
  endtask

  task automatic drain();
    int g = 0;
    while ((q.size() != 0 || !in_ready || q1.size() != 0 || !in_ready1) && g < 1000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 1000) begin
      checks++; fails++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size() + q1.size());
    end
  endtask

  // Monitor for the SLICE=4 instance.
  initial begin
    bit   seen = 0;
    bit   rel_pend = 0;
    int   dwell = 0;
    res_t exp;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rel_pend) begin
        chk("release_out_valid", {31'b0, out_valid}, 32'd0);
        chk("release_in_ready", {31'b0, in_ready}, 32'd1);
        rel_pend = 0;
      end
      if (out_valid && !rst) begin
        if (q.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_out_valid: got out_valid=1, required 0 (no op pending)");
          out_ready = 1'b1;
        end else begin
          exp = q[0];
          if (!seen) begin
            seen = 1;
            chk("latency", cyc - stamp_q[0], 32'd4);
            dwell = force_bp ? 3 : $urandom_range(0, 2);
          end
          chk("result", {12'b0, d, cout, ovf, zero, neg}, {12'b0, exp});
          chk("in_ready_in_done", {31'b0, in_ready}, 32'd0);
          if (dwell > 0) begin
            out_ready = 1'b0;
            dwell--;
          end else begin
            out_ready = 1'b1;
            void'(q.pop_front());
            void'(stamp_q.pop_front());
            seen = 0;
            rel_pend = 1;
          end
        end
      end else begin
        out_ready = 1'b0;
      end
    end
  end

  // Monitor for the SLICE=16 instance; always ready, so DONE lasts one cycle.
  initial begin
    res_t exp;
    out_ready1 = 1'b1;
    forever begin
      @(negedge clk);
      if (out_valid1 && !rst) begin
        if (q1.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_out_valid1: got out_valid1=1, required 0");
        end else begin
          exp = q1.pop_front();
          chk("latency_n1", cyc - stamp1_q.pop_front(), 32'd1);
          chk("result_n1", {12'b0, d1, cout1, ovf1, zero1, neg1}, {12'b0, exp});
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; x = '0; y = '0; cin = 1'b0; sel = 2'b00;
    in_valid1 = 1'b0; x1 = '0; y1 = '0; cin1 = 1'b0; sel1 = 2'b00;
    #12;
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_d_flags", {12'b0, d, cout, ovf, zero, neg}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases, back to back, each held three cycles in DONE while the
    // next request churns its operands.
    force_bp = 1;
    send(16'h1234, 16'h0F0F, 1'b0, 2'b00, 1);
    send(16'h0005, 16'h0007, 1'b1, 2'b01, 1);
    send(16'h0007, 16'h0005, 1'b1, 2'b01, 1);
    send(16'h7FFF, 16'h0001, 1'b0, 2'b00, 1);
    send(16'hFFFF, 16'hABCD, 1'b1, 2'b10, 1);
    send(16'h0001, 16'h1357, 1'b0, 2'b11, 1);
    send(16'h0000, 16'h2468, 1'b0, 2'b11, 1);
    drain();
    force_bp = 0;

    for (int i = 0; i < 40; i++)
      send(pick(), pick(), 1'($urandom), 2'($urandom), 1);
    drain();

    // Reset two cycles into BUSY: the partially built d must vanish at once.
    send(16'h1234, 16'h0F0F, 1'b0, 2'b00, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_d_flags", {12'b0, d, cout, ovf, zero, neg}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) @(negedge clk);
    send(16'h8000, 16'h8000, 1'b0, 2'b00, 1);
    send(16'h1234, 16'h1234, 1'b1, 2'b01, 1);
    drain();

    // Single-slice instance.
    send1(16'h1234, 16'h0F0F, 1'b0, 2'b00);
    for (int i = 0; i < 10; i++)
      send1(pick(), pick(), 1'($urandom), 2'($urandom));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "timeout");
  end

endmodule
